// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL (low word) / DIVU / REMU sequencer that borrows the datapath ALU,
// one add or subtract per cycle: shift-add multiply, restoring shift-subtract divide.
module alu_muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FlagSize   = 4,
    parameter int unsigned AluOpWidth = 4,
    parameter logic [AluOpWidth-1:0] AddOp = 4'd0,
    parameter logic [AluOpWidth-1:0] SubOp = 4'd1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [AluOpWidth-1:0] alu_op_o,
    input  logic [DATA_WIDTH-1:0] alu_y_i,
    input  logic [FlagSize-1:0]   alu_flags_i
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StMulIt, StDivIt, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] r_sh;
    logic                  ob;
    logic                  take;
    logic                  last_it;
    logic                  unused_flags;

    // Only the carry (borrow) flag matters to the divide step.
    assign unused_flags = ^{alu_flags_i[FlagSize-1:2], alu_flags_i[0]};

    assign r_sh    = {acc_q[DATA_WIDTH-2:0], op_a_q[DATA_WIDTH-1]};
    assign ob      = acc_q[DATA_WIDTH-1];
    // A shifted-out remainder bit means r_sh really exceeds the divisor, even if the ALU borrows.
    assign take    = ob | ~alu_flags_i[1];
    assign last_it = (cnt_q == CntW'(1));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = 1'b0;
        alu_op_o = AddOp;
        alu_a_o  = '0;
        alu_b_o  = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d   = op_i;
                    op_a_d = a_i;
                    op_b_d = b_i;
                    acc_d  = '0;
                    cnt_d  = CntW'(DATA_WIDTH);
                    unique case (op_i)
                        2'b00: state_d = StMulIt;
                        2'b01: begin
                            if (b_i == '0) begin
                                state_d  = StDone;
                                result_d = '1;
                            end else begin
                                state_d = StDivIt;
                            end
                        end
                        2'b10: begin
                            if (b_i == '0) begin
                                state_d  = StDone;
                                result_d = a_i;
                            end else begin
                                state_d = StDivIt;
                            end
                        end
                        default: begin
                            state_d  = StDone;
                            result_d = '0;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
            StMulIt: begin
                alu_op_o = AddOp;
                alu_a_o  = acc_q;
                alu_b_o  = op_b_q[0] ? op_a_q : '0;
                acc_d    = alu_y_i;
                op_a_d   = op_a_q << 1;
                op_b_d   = op_b_q >> 1;
                cnt_d    = cnt_q - CntW'(1);
                if (last_it) begin
                    state_d  = StDone;
                    result_d = alu_y_i;
                end
            end
            StDivIt: begin
                alu_op_o = SubOp;
                alu_a_o  = r_sh;
                alu_b_o  = op_b_q;
                acc_d    = take ? alu_y_i : r_sh;
                op_a_d   = {op_a_q[DATA_WIDTH-2:0], take};
                cnt_d    = cnt_q - CntW'(1);
                if (last_it) begin
                    state_d  = StDone;
                    result_d = (op_q == 2'b01) ? op_a_d : acc_d;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign err_o    = err_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer: directed vector table, multi-cycle corner
// sequences (reset mid-op, start held high) and random operands against a behavioural model.
module tb_alu_muldiv_sequencer;

    localparam int unsigned W = 32;
    localparam logic [3:0] AddOp = 4'd0;
    localparam logic [3:0] SubOp = 4'd1;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o, done_o, err_o;
    logic [W-1:0] result_o, alu_a, alu_b, alu_y;
    logic [3:0]   alu_op, alu_flags;
    logic         alu_c;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    alu_muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .result_o   (result_o),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_op_o   (alu_op),
        .alu_y_i    (alu_y),
        .alu_flags_i(alu_flags)
    );

    // Behavioural ALU: flags VNCZ, C is carry-out for add and borrow for subtract.
    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        case (alu_op)
            AddOp:   {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            SubOp:   {alu_c, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
            default: ;
        endcase
        alu_flags = {1'b0, alu_y[W-1], alu_c, (alu_y == '0)};
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         err;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_res(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            2'b00:   return a * b;
            2'b01:   return (b == '0) ? '1 : a / b;
            2'b10:   return (b == '0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (op == 2'b11 || (op != 2'b00 && b == '0)) return 1;
        return W + 1;
    endfunction

    task automatic check_idle(input string tag, input logic [W-1:0] exp_res);
        check({tag, " idle flags"}, {29'd0, busy_o, done_o, err_o}, '0);
        check({tag, " idle alu op"}, {28'd0, alu_op}, {28'd0, AddOp});
        check({tag, " idle alu a|b"}, alu_a | alu_b, '0);
        check({tag, " result hold"}, result_o, exp_res);
    endtask

    // One start pulse; inputs are scrambled right after acceptance.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_err, input int exp_lat, input bit full);
        int lat;
        logic busy_bad, err_bad, err_seen;
        logic [W-1:0] res;
        lat = 0; busy_bad = 1'b0; err_bad = 1'b0; err_seen = 1'b0; res = '0;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk_i);
        start_i = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
        for (int n = 1; n <= 40; n++) begin
            if (!busy_o) busy_bad = 1'b1;
            if (done_o) begin
                lat = n; res = result_o; err_seen = err_o;
                break;
            end
            if (err_o) err_bad = 1'b1;
            @(negedge clk_i);
        end
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        check({tag, " result"}, res, exp_res);
        check({tag, " err"}, {31'd0, err_seen}, {31'd0, exp_err});
        if (full) begin
            check({tag, " busy throughout"}, {31'd0, busy_bad}, '0);
            check({tag, " err early"}, {31'd0, err_bad}, '0);
            @(negedge clk_i);
            check_idle(tag, exp_res);
        end
    endtask

    vec_t vecs[15];

    initial begin
        int first_done, second_done, late_done;
        logic busy34, busy35;

        vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         1'b0, 33};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 33};
        vecs[2]  = '{2'b00, 32'h8000_0000,  32'd2,          32'd0,          1'b0, 33};
        vecs[3]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 33};
        vecs[4]  = '{2'b10, 32'd100,        32'd7,          32'd2,          1'b0, 33};
        vecs[5]  = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          1'b0, 33};
        vecs[6]  = '{2'b10, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  1'b0, 33};
        vecs[7]  = '{2'b01, 32'd5,          32'd9,          32'd0,          1'b0, 33};
        vecs[8]  = '{2'b10, 32'd5,          32'd9,          32'd5,          1'b0, 33};
        vecs[9]  = '{2'b01, 32'd123,        32'd0,          32'hFFFF_FFFF,  1'b0, 1};
        vecs[10] = '{2'b10, 32'd123,        32'd0,          32'd123,        1'b0, 1};
        vecs[11] = '{2'b11, 32'd55,         32'd3,          32'd0,          1'b1, 1};
        vecs[12] = '{2'b01, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  1'b0, 33};
        vecs[13] = '{2'b10, 32'd0,          32'd7,          32'd0,          1'b0, 33};
        vecs[14] = '{2'b00, 32'h1234_5678,  32'd0,          32'd0,          1'b0, 33};

        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        check_idle("reset", '0);

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].err, vecs[i].lat, 1'b1);
        end

        // Reset during the tenth DIVU iteration cycle abandons the operation.
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b01; a_i = 32'd100; b_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        check_idle("mid reset", '0);
        late_done = 0;
        for (int n = 0; n < 40; n++) begin
            if (done_o) late_done++;
            @(negedge clk_i);
        end
        check("mid reset no done", W'(late_done), '0);
        run_op("mul after reset", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0, 33, 1'b1);

        // start_i held high: second MUL is accepted in T+34 and completes in T+67.
        first_done = 0; second_done = 0; busy34 = 1'b1; busy35 = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; a_i = 32'd3; b_i = 32'd5;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk_i);
            if (done_o) begin
                if (first_done == 0) first_done = n;
                else if (second_done == 0) second_done = n;
            end
            if (n == 34) busy34 = busy_o;
            if (n == 35) begin
                busy35 = busy_o;
                start_i = 1'b0;
            end
        end
        check("held start first done", W'(first_done), 32'd33);
        check("held start idle gap", {31'd0, busy34}, '0);
        check("held start reaccept", {31'd0, busy35}, 32'd1);
        check("held start second done", W'(second_done), 32'd67);
        check("held start result", result_o, 32'd15);

        for (int op = 0; op < 3; op++) begin
            for (int k = 0; k < 150; k++) begin
                logic [W-1:0] a, b;
                a = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
                case ($urandom_range(0, 9))
                    0:       b = 32'd1;
                    1:       b = 32'd0;
                    2:       b = W'($urandom_range(2, 300));
                    default: b = W'($urandom);
                endcase
                run_op($sformatf("rand op%0d a=%08h b=%08h", op, a, b), 2'(op), a, b,
                       model_res(2'(op), a, b), 1'b0, model_lat(2'(op), b), (k % 25) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
